// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-segment scan controller with double-buffered digit data.
// Define DISP_BLINK_EN to add the staged blink_mask input and the blink phase counter.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS     = 8,
  parameter int CLK_DIV        = 50000,
  parameter int SPLIT          = 4,
  parameter bit AN_ACTIVE_LOW  = 1'b0,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter int BLINK_DIV      = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] show_data,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lz_en,
`ifdef DISP_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  output logic [7:0]              seg,
  output logic [7:0]              seg1,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_ACTIVE_LOW}};
  localparam logic [7:0]            SEG_OFF = {8{SEG_ACTIVE_LOW}};

  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    logic [7:0] code;
    unique case (nib)
      4'h0: code = 8'hFC;
      4'h1: code = 8'h60;
      4'h2: code = 8'hDA;
      4'h3: code = 8'hF2;
      4'h4: code = 8'h66;
      4'h5: code = 8'hB6;
      4'h6: code = 8'hBE;
      4'h7: code = 8'hE0;
      4'h8: code = 8'hFE;
      4'h9: code = 8'hF6;
      4'hA: code = 8'hEE;
      4'hB: code = 8'h3E;
      4'hC: code = 8'h9C;
      4'hD: code = 8'h7A;
      4'hE: code = 8'h9E;
      default: code = 8'h8E;
    endcase
    return code;
  endfunction

  logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    pending_q, pending_d;
  logic [4*NUM_DIGITS-1:0] data_stg_q, data_stg_d, data_act_q, data_act_d;
  logic [NUM_DIGITS-1:0]   dp_stg_q, dp_stg_d, dp_act_q, dp_act_d;
  logic [NUM_DIGITS-1:0]   blank_stg_q, blank_stg_d, blank_act_q, blank_act_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [7:0]              seg_q, seg_d, seg1_q, seg1_d;
  logic                    frame_done_q, frame_done_d;

  logic                    tick, wrap_tick, transfer, blink_dark;
  logic [IDX_W-1:0]        hi_nz;
  logic [4*NUM_DIGITS-1:0] digit_bits;
  logic [7:0]              code;

  assign tick      = (div_cnt_q == DIV_W'(CLK_DIV - 1));
  assign wrap_tick = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));
  assign transfer  = wrap_tick && pending_q;

  // Highest nonzero digit of the active snapshot bounds leading-zero suppression.
  always_comb begin
    hi_nz = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (data_act_q[4*k +: 4] != 4'h0) hi_nz = IDX_W'(k);
    end
  end

  always_comb begin
    digit_bits = data_act_q >> {idx_q, 2'b00};
    code = seg_decode(digit_bits[3:0]);
    if (lz_en && (idx_q > hi_nz)) code = 8'h00;
    code = code | {7'b0, dp_act_q[idx_q]};
    if (blank_act_q[idx_q] || blink_dark) code = 8'h00;
  end

  always_comb begin
    div_cnt_d    = tick ? '0 : div_cnt_q + DIV_W'(1);
    idx_d        = idx_q;
    data_stg_d   = load ? show_data : data_stg_q;
    dp_stg_d     = load ? dp_mask : dp_stg_q;
    blank_stg_d  = load ? blank_mask : blank_stg_q;
    pending_d    = load || (pending_q && !wrap_tick);
    data_act_d   = transfer ? data_stg_q : data_act_q;
    dp_act_d     = transfer ? dp_stg_q : dp_act_q;
    blank_act_d  = transfer ? blank_stg_q : blank_act_q;
    an_d         = an_q;
    seg_d        = seg_q;
    seg1_d       = seg1_q;
    frame_done_d = wrap_tick;
    // The digit at idx_q is latched onto the outputs at its tick, then the index moves on.
    if (tick) begin
      idx_d = wrap_tick ? '0 : idx_q + IDX_W'(1);
      an_d  = AN_OFF ^ (NUM_DIGITS'(1) << idx_q);
      if (int'(idx_q) >= SPLIT) begin
        seg_d  = code ^ SEG_OFF;
        seg1_d = SEG_OFF;
      end else begin
        seg_d  = SEG_OFF;
        seg1_d = code ^ SEG_OFF;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q    <= '0;
      idx_q        <= '0;
      pending_q    <= 1'b0;
      data_stg_q   <= '0;
      dp_stg_q     <= '0;
      blank_stg_q  <= '0;
      data_act_q   <= '0;
      dp_act_q     <= '0;
      blank_act_q  <= '0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      seg1_q       <= SEG_OFF;
      frame_done_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      data_stg_q   <= data_stg_d;
      dp_stg_q     <= dp_stg_d;
      blank_stg_q  <= blank_stg_d;
      data_act_q   <= data_act_d;
      dp_act_q     <= dp_act_d;
      blank_act_q  <= blank_act_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      seg1_q       <= seg1_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef DISP_BLINK_EN
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [NUM_DIGITS-1:0] blink_stg_q, blink_stg_d, blink_act_q, blink_act_d;
  logic [BLK_W-1:0]      blink_cnt_q, blink_cnt_d;
  logic                  phase_q, phase_d;

  // Phase only changes at frame boundaries so a frame never blinks partway through.
  always_comb begin
    blink_stg_d = load ? blink_mask : blink_stg_q;
    blink_act_d = transfer ? blink_stg_q : blink_act_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (wrap_tick) begin
      if (blink_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLK_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_stg_q <= '0;
      blink_act_q <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      blink_stg_q <= blink_stg_d;
      blink_act_q <= blink_act_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign blink_dark = phase_q && blink_act_q[idx_q];
`else
  assign blink_dark = 1'b0;
`endif

  assign seg        = seg_q;
  assign seg1       = seg1_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: self-checking bench for seg_scan_ctrl with CLK_DIV=4, 8 digits, SPLIT=4.
// A frame-level reference model is compared every cycle, alongside hand-computed spot checks.
`timescale 1ns/1ps
module tb_seg_scan_ctrl;

  localparam int NUM_DIGITS = 8;
  localparam int CLK_DIV    = 4;
  localparam int SPLIT      = 4;
  localparam int BLINK_DIV  = 2;
`ifdef DISP_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] show_data = '0;
  logic        load = 1'b0;
  logic [7:0]  dp_mask = '0;
  logic [7:0]  blank_mask = '0;
  logic [7:0]  blink_mask = '0;
  logic        lz_en = 1'b0;
  logic [7:0]  seg, seg1, an;
  logic        frame_done;

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  seg_scan_ctrl #(
    .NUM_DIGITS(NUM_DIGITS), .CLK_DIV(CLK_DIV), .SPLIT(SPLIT),
    .AN_ACTIVE_LOW(1'b0), .SEG_ACTIVE_LOW(1'b0), .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk(clk), .rst(rst), .show_data(show_data), .load(load),
    .dp_mask(dp_mask), .blank_mask(blank_mask), .lz_en(lz_en),
`ifdef DISP_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .seg(seg), .seg1(seg1), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Reference model: digit/frame position follows from the edge count since reset.
  logic [7:0]  seg_table [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                  8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};
  int          m_edges = 0, m_tick = 0, m_frame = -1, m_digit = -1;
  logic [31:0] m_stg_data = '0, m_act_data = '0;
  logic [7:0]  m_stg_dp = '0, m_act_dp = '0, m_stg_blank = '0, m_act_blank = '0;
  logic [7:0]  m_stg_blink = '0, m_act_blink = '0;
  logic [7:0]  exp_an = '0, exp_seg = '0, exp_seg1 = '0;
  logic        exp_fd = 1'b0;

  function automatic logic [7:0] digitCode(input int d, input int f);
    logic [31:0] data;
    logic [7:0]  c;
    int          hi;
    data = m_act_data;
    hi = 0;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (((data >> (4 * k)) & 32'hF) != 0) hi = k;
    c = seg_table[(data >> (4 * d)) & 32'hF];
    if (lz_en && d > hi) c = 8'h00;
    if (m_act_dp[d]) c = c | 8'h01;
    if (m_act_blank[d]) c = 8'h00;
    if (BLINK_ON && m_act_blink[d] && ((f / BLINK_DIV) % 2 == 1)) c = 8'h00;
    return c;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_edges = 0; m_frame = -1; m_digit = -1;
      m_stg_data = '0; m_act_data = '0; m_stg_dp = '0; m_act_dp = '0;
      m_stg_blank = '0; m_act_blank = '0; m_stg_blink = '0; m_act_blink = '0;
      exp_an = '0; exp_seg = '0; exp_seg1 = '0; exp_fd = 1'b0;
    end else begin
      m_edges++;
      exp_fd = 1'b0;
      if (m_edges % CLK_DIV == 0) begin
        m_tick  = m_edges / CLK_DIV - 1;
        m_digit = m_tick % NUM_DIGITS;
        m_frame = m_tick / NUM_DIGITS;
        exp_an  = 8'h01 << m_digit;
        if (m_digit >= SPLIT) begin
          exp_seg  = digitCode(m_digit, m_frame);
          exp_seg1 = 8'h00;
        end else begin
          exp_seg  = 8'h00;
          exp_seg1 = digitCode(m_digit, m_frame);
        end
        if (m_digit == NUM_DIGITS - 1) begin
          exp_fd      = 1'b1;
          m_act_data  = m_stg_data;
          m_act_dp    = m_stg_dp;
          m_act_blank = m_stg_blank;
          m_act_blink = m_stg_blink;
        end
      end
      if (load) begin
        m_stg_data = show_data; m_stg_dp = dp_mask;
        m_stg_blank = blank_mask; m_stg_blink = blink_mask;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic checkDigit(input string name, input logic [7:0] e_an,
                            input logic [7:0] e_seg, input logic [7:0] e_seg1);
    checkOutput({name, "_an"}, 32'(an), 32'(e_an));
    checkOutput({name, "_seg"}, 32'(seg), 32'(e_seg));
    checkOutput({name, "_seg1"}, 32'(seg1), 32'(e_seg1));
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("cyc_an", 32'(an), 32'(exp_an));
      checkOutput("cyc_seg", 32'(seg), 32'(exp_seg));
      checkOutput("cyc_seg1", 32'(seg1), 32'(exp_seg1));
      checkOutput("cyc_frame_done", 32'(frame_done), 32'(exp_fd));
    end
  end

  task automatic applyStimulus(input logic [31:0] data, input logic [7:0] dp,
                               input logic [7:0] blank, input logic [7:0] blink);
    show_data = data; dp_mask = dp; blank_mask = blank; blink_mask = blink;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Returns on the first negedge where digit d of frame f is on the outputs.
  task automatic waitFor(input int f, input int d);
    int budget;
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!(m_frame == f && m_digit == d && m_edges % CLK_DIV == 0) && budget < 2000);
    if (!(m_frame == f && m_digit == d)) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_f%0d_d%0d: reached frame %0d digit %0d, required frame %0d digit %0d",
               f, d, m_frame, m_digit, f, d);
    end
  endtask

  task automatic checkStartup();
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= CLK_DIV; k++) begin
      @(negedge clk);
      checkOutput("startup_an", 32'(an), (k == CLK_DIV) ? 32'h01 : 32'h00);
    end
    checkOutput("startup_seg1", 32'(seg1), 32'hFC);
  endtask

  initial begin
    #1 rst = 1'b0;
    check_en = 1'b1;
    #1;
    checkDigit("reset_async", 8'h00, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    checkOutput("reset_fd", 32'(frame_done), 32'h0);
    checkStartup();

    applyStimulus(32'h12345678, 8'h00, 8'h00, 8'h00);
    waitFor(1, 0); checkDigit("load_d0", 8'h01, 8'h00, 8'hFE);
    waitFor(1, 7); checkDigit("load_d7", 8'h80, 8'h60, 8'h00);
    checkOutput("load_fd", 32'(frame_done), 32'h1);

    waitFor(2, 3); applyStimulus(32'hFFFFFFFF, 8'h00, 8'h00, 8'h00);
    waitFor(2, 5); checkDigit("midload_old_d5", 8'h20, 8'hF2, 8'h00);
    waitFor(2, 7); checkOutput("midload_fd_hi", 32'(frame_done), 32'h1);
    @(negedge clk); checkOutput("midload_fd_lo", 32'(frame_done), 32'h0);

    waitFor(3, 1); lz_en = 1'b1; applyStimulus(32'h00000A05, 8'h00, 8'h00, 8'h00);
    waitFor(3, 5); checkDigit("midload_new_d5", 8'h20, 8'h8E, 8'h00);
    waitFor(4, 0); checkDigit("lz_d0", 8'h01, 8'h00, 8'hB6);
    waitFor(4, 1); checkDigit("lz_d1", 8'h02, 8'h00, 8'hFC);
    waitFor(4, 2); checkDigit("lz_d2", 8'h04, 8'h00, 8'hEE);
    waitFor(4, 3); checkDigit("lz_d3", 8'h08, 8'h00, 8'h00);
    waitFor(4, 7); checkDigit("lz_d7", 8'h80, 8'h00, 8'h00);

    waitFor(5, 0); lz_en = 1'b0; applyStimulus(32'h00000000, 8'h10, 8'h01, 8'h00);
    waitFor(6, 0); checkDigit("blank_d0", 8'h01, 8'h00, 8'h00);
    waitFor(6, 1);
    applyStimulus(32'h9ABCDEF0, 8'h00, 8'h00, 8'h00);
    applyStimulus(32'h0FEDCBA9, 8'hAA, 8'h00, 8'h00);
    waitFor(6, 4); checkDigit("dp_d4", 8'h10, 8'hFD, 8'h00);
    waitFor(7, 0); checkDigit("last_wins_d0", 8'h01, 8'h00, 8'hF6);
    waitFor(7, 1); checkDigit("last_wins_d1", 8'h02, 8'h00, 8'hEF);

    waitFor(7, 6); repeat (3) @(negedge clk);
    applyStimulus(32'h11111111, 8'h00, 8'h00, 8'h00);
    waitFor(8, 0); checkDigit("wrapload_f8", 8'h01, 8'h00, 8'hF6);
    waitFor(9, 0); checkDigit("wrapload_f9", 8'h01, 8'h00, 8'h60);

    waitFor(9, 2); applyStimulus(32'h77777777, 8'h00, 8'h00, 8'h00);
    waitFor(9, 3);
    #2 rst = 1'b0;
    #1;
    checkDigit("midreset", 8'h00, 8'h00, 8'h00);
    checkOutput("midreset_fd", 32'(frame_done), 32'h0);
    repeat (2) @(negedge clk);
    checkStartup();
    waitFor(1, 0); checkDigit("discard_d0", 8'h01, 8'h00, 8'hFC);

    applyStimulus(32'h00000000, 8'h00, 8'h00, 8'h80);
    for (int f = 1; f <= 5; f++) begin
      waitFor(f, 7);
      checkDigit($sformatf("blink_f%0d", f), 8'h80,
                 (BLINK_ON && (f == 2 || f == 3)) ? 8'h00 : 8'hFC, 8'h00);
    end

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
